// File: rtl/multi_line_swap_buffer.sv
// multi_line_swap_buffer
// Schedules N_CAM line buffers onto one packetiser read port. Each trigger runs the
// enabled cameras in ascending index order. A camera gets a trig pulse, the block waits for
// its busy to drop, and the read port is routed to it. The block also provides a busy
// watchdog, a one-deep trigger queue and sticky error flags.
//
// state | meaning
// IDLE  | no sequence running; last served camera stays routed
// TRIG  | launch ch_trig for camera cur, load watchdog timer
// ARM   | ch_trig visible to the line buffer; ch_busy not yet valid
// WAIT  | wait for ch_busy[cur] low or watchdog terminal count
module multi_line_swap_buffer #(
    parameter int N_CAM   = 4,
    parameter int DW      = 16,
    parameter int RW      = 11,
    parameter int TIMEOUT = 65535,
    localparam int CW     = $clog2(N_CAM)
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                trig,
    input  logic                clr,
    input  logic [N_CAM-1:0]    cam_en,
    output logic [N_CAM-1:0]    ch_trig,
    input  logic [N_CAM-1:0]    ch_busy,
    input  logic [N_CAM-1:0]    ch_aquire,
    input  logic [N_CAM*DW-1:0] ch_data,
    input  logic [N_CAM*RW-1:0] ch_row,
    input  logic [N_CAM-1:0]    ch_err,
    output logic [N_CAM-1:0]    ch_re,
    input  logic                read_en,
    output logic                aquire,
    output logic [DW-1:0]       cam_data,
    output logic [RW-1:0]       cam_row,
    output logic [CW-1:0]       cam_idx,
    output logic [N_CAM-1:0]    cam_id,
    output logic                busy,
    output logic                done,
    output logic [N_CAM-1:0]    timeout,
    output logic                error
);

    // Watchdog is a down-counter loaded with TIMEOUT-1; terminal count at zero matches
    // an up-count reaching TIMEOUT-1.
    localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMW-1:0] TMR_LOAD = TMW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_TRIG, S_ARM, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cur, cur_nxt;
    logic [N_CAM-1:0] mask, mask_nxt;
    logic [TMW-1:0]   timer, timer_nxt;
    logic             busy_nxt, done_nxt;
    logic             pending, pending_nxt;
    logic             trig_drop, drop_set;
    logic [N_CAM-1:0] to_set;
    logic [N_CAM-1:0] cur_oh;
    logic [CW-1:0]    first_cam, next_cam;
    logic             has_next;
    logic             wd_hit;

    assign cur_oh = {{(N_CAM-1){1'b0}}, 1'b1} << cur;
    assign wd_hit = (TIMEOUT != 0) && (timer == '0);

    // Read-port routing: everything follows cur, including in IDLE
    always_comb begin
        aquire   = ch_aquire[cur];
        cam_data = ch_data[int'(cur)*DW +: DW];
        cam_row  = ch_row[int'(cur)*RW +: RW];
        cam_idx  = cur;
        cam_id   = {1'b1, {(N_CAM-1){1'b0}}} >> cur;
        ch_re    = read_en ? cur_oh : '0;
        error    = (|ch_err) | (|timeout) | trig_drop;
    end

    // Camera selection: lowest enabled camera, and next latched camera above cur
    always_comb begin
        first_cam = '0;
        for (int i = N_CAM - 1; i >= 0; i--) begin
            if (cam_en[i]) first_cam = CW'(i);
        end
        has_next = 1'b0;
        next_cam = cur;
        for (int i = N_CAM - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                has_next = 1'b1;
                next_cam = CW'(i);
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        mask_nxt  = mask;
        timer_nxt = timer;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        to_set    = '0;
        // Any request seen in IDLE is consumed; outside IDLE it is queued one deep
        pending_nxt = (state == S_IDLE) ? 1'b0 : (pending | trig);
        drop_set    = (state != S_IDLE) && trig && pending;
        case (state)
            S_IDLE: begin
                if ((trig || pending) && (cam_en != '0)) begin
                    mask_nxt  = cam_en;
                    cur_nxt   = first_cam;
                    busy_nxt  = 1'b1;
                    state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                timer_nxt = TMR_LOAD;
                state_nxt = S_ARM;
            end
            S_ARM: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (timer != '0) timer_nxt = timer - 1'b1;
                if (!ch_busy[cur] || wd_hit) begin
                    // Flag only a camera that really hung at terminal count
                    if (ch_busy[cur]) to_set = cur_oh;
                    if (has_next) begin
                        cur_nxt   = next_cam;
                        state_nxt = S_TRIG;
                    end else begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers; sticky flags give set priority over clr
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            mask      <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pending   <= 1'b0;
            trig_drop <= 1'b0;
            timeout   <= '0;
            ch_trig   <= '0;
        end else begin
            cur       <= cur_nxt;
            mask      <= mask_nxt;
            timer     <= timer_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pending   <= pending_nxt;
            trig_drop <= drop_set | (trig_drop & ~clr);
            timeout   <= to_set | (timeout & ~{N_CAM{clr}});
            ch_trig   <= (state == S_TRIG) ? cur_oh : '0;
        end
    end

endmodule

// File: tb/tb_multi_line_swap_buffer.sv
// Directed bench for multi_line_swap_buffer with four cameras and a 100-cycle watchdog.
// Line buffers are modelled as busy for BUSY_LEN cycles after their trig pulse.
module tb_multi_line_swap_buffer;

    localparam int N = 4;
    localparam int DW = 16;
    localparam int RW = 11;
    localparam int BUSY_LEN = 10;

    logic          rclk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          clr = 1'b0;
    logic [N-1:0]  cam_en = '0;
    logic [N-1:0]  ch_trig;
    logic [N-1:0]  ch_busy;
    logic [N-1:0]  ch_aquire = 4'b0110;
    logic [N*DW-1:0] ch_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
    logic [N*RW-1:0] ch_row = {11'd403, 11'd302, 11'd201, 11'd100};
    logic [N-1:0]  ch_err = '0;
    logic [N-1:0]  ch_re;
    logic          read_en = 1'b0;
    logic          aquire;
    logic [DW-1:0] cam_data;
    logic [RW-1:0] cam_row;
    logic [1:0]    cam_idx;
    logic [N-1:0]  cam_id;
    logic          busy;
    logic          done;
    logic [N-1:0]  timeout;
    logic          error;

    int tests = 0;
    int fails = 0;

    multi_line_swap_buffer #(.N_CAM(N), .DW(DW), .RW(RW), .TIMEOUT(100)) dut (
        .rclk(rclk), .rst(rst), .trig(trig), .clr(clr), .cam_en(cam_en),
        .ch_trig(ch_trig), .ch_busy(ch_busy), .ch_aquire(ch_aquire),
        .ch_data(ch_data), .ch_row(ch_row), .ch_err(ch_err), .ch_re(ch_re),
        .read_en(read_en), .aquire(aquire), .cam_data(cam_data), .cam_row(cam_row),
        .cam_idx(cam_idx), .cam_id(cam_id), .busy(busy), .done(done),
        .timeout(timeout), .error(error)
    );

    always #5 rclk = ~rclk;

    // Line buffer model
    logic [N-1:0]      stuck = '0;
    logic [N-1:0][7:0] bcnt;
    always @(posedge rclk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) bcnt[i] <= 8'd0;
            else if (ch_trig[i]) bcnt[i] <= 8'(BUSY_LEN);
            else if (bcnt[i] != 8'd0) bcnt[i] <= bcnt[i] - 8'd1;
        end
    end
    always_comb begin
        for (int i = 0; i < N; i++) ch_busy[i] = (bcnt[i] != 8'd0) | stuck[i];
    end

    // Observation logs, sampled mid-cycle
    logic [3:0] trig_log[$];
    logic [3:0] id_log[$];
    logic [3:0] idx_log[$];
    int  done_cnt = 0;
    bit  busy_seen = 0;
    bit  chk_re = 0;
    always @(negedge rclk) begin
        if (!rst) begin
            if (ch_trig != '0) begin
                trig_log.push_back(ch_trig);
                id_log.push_back(cam_id);
                idx_log.push_back({2'b00, cam_idx});
            end
            if (done) done_cnt++;
            if (busy) busy_seen = 1;
        end
        if (chk_re) begin
            tests++;
            if (ch_re !== (4'b0001 << cam_idx)) begin
                fails++; $display("FAIL re_route: ch_re=%b want %b", ch_re, 4'b0001 << cam_idx);
            end
            tests++;
            if (cam_id !== (4'b1000 >> cam_idx)) begin
                fails++; $display("FAIL re_id: cam_id=%b want %b", cam_id, 4'b1000 >> cam_idx);
            end
            tests++;
            if (cam_data !== ch_data[int'(cam_idx)*DW +: DW]) begin
                fails++; $display("FAIL re_data: cam_data=%h want %h", cam_data, ch_data[int'(cam_idx)*DW +: DW]);
            end
            tests++;
            if (cam_row !== ch_row[int'(cam_idx)*RW +: RW] || aquire !== ch_aquire[cam_idx]) begin
                fails++; $display("FAIL re_row_aq: row=%0d aq=%b want %0d %b", cam_row, aquire,
                                  ch_row[int'(cam_idx)*RW +: RW], ch_aquire[cam_idx]);
            end
        end
    end

    function automatic logic [15:0] packed_log(input int which);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            if (which == 0 && k < trig_log.size()) p[(15-4*k) -: 4] = trig_log[k];
            if (which == 1 && k < id_log.size())   p[(15-4*k) -: 4] = id_log[k];
            if (which == 2 && k < idx_log.size())  p[(15-4*k) -: 4] = idx_log[k];
        end
        return p;
    endfunction

    task automatic clear_logs();
        trig_log.delete(); id_log.delete(); idx_log.delete();
        done_cnt = 0; busy_seen = 0;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        @(posedge rclk); #1;
        trig = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge rclk); #1;
        clr = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge rclk); #1;
            if (done_cnt >= n) ok = 1;
        end
    endtask

    task automatic wait_trig(input logic [3:0] v, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge rclk); #1;
            if (ch_trig === v) ok = 1;
        end
    endtask

    task automatic test_reset();
        read_en = 1'b1;
        #1;
        tests++;
        if (ch_trig !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: ch_trig=%b busy=%b done=%b want 0000 0 0", ch_trig, busy, done);
        end
        tests++;
        if (timeout !== 4'b0000 || error !== 1'b0) begin
            fails++; $display("FAIL reset_err: timeout=%b error=%b want 0000 0", timeout, error);
        end
        tests++;
        if (cam_idx !== 2'd0 || cam_id !== 4'b1000 || ch_re !== 4'b0001) begin
            fails++; $display("FAIL reset_route: idx=%0d id=%b re=%b want 0 1000 0001", cam_idx, cam_id, ch_re);
        end
        tests++;
        if (cam_data !== 16'h0F0F || aquire !== 1'b0) begin
            fails++; $display("FAIL reset_data: data=%h aq=%b want 0f0f 0", cam_data, aquire);
        end
        read_en = 1'b0;
        @(posedge rclk); #1;
        rst = 1'b0;
        @(posedge rclk); #1;
    endtask

    task automatic test_all_cams();
        bit ok;
        cam_en = 4'b1111;
        clear_logs();
        pulse_trig();
        tests++;
        if (busy !== 1'b1 || ch_trig !== 4'b0000) begin
            fails++; $display("FAIL lat_edge1: busy=%b ch_trig=%b want 1 0000", busy, ch_trig);
        end
        @(posedge rclk); #1;
        tests++;
        if (ch_trig !== 4'b0001) begin
            fails++; $display("FAIL lat_edge2: ch_trig=%b want 0001", ch_trig);
        end
        wait_done(1, 300, ok);
        repeat (3) @(posedge rclk);
        #1;
        tests++;
        if (!ok) begin fails++; $display("FAIL all_done_wait: done not seen, want 1 pulse"); end
        tests++;
        if (trig_log.size() !== 4 || packed_log(0) !== 16'h1248) begin
            fails++; $display("FAIL all_trig_order: n=%0d log=%h want 4 1248", trig_log.size(), packed_log(0));
        end
        tests++;
        if (packed_log(1) !== 16'h8421) begin
            fails++; $display("FAIL all_cam_id: log=%h want 8421", packed_log(1));
        end
        tests++;
        if (done_cnt !== 1 || busy !== 1'b0 || cam_idx !== 2'd3) begin
            fails++; $display("FAIL all_end: done_cnt=%0d busy=%b idx=%0d want 1 0 3", done_cnt, busy, cam_idx);
        end
    endtask

    task automatic test_mask();
        bit ok;
        cam_en = 4'b1010;
        clear_logs();
        pulse_trig();
        cam_en = 4'b0101;
        wait_done(1, 300, ok);
        repeat (3) @(posedge rclk);
        #1;
        tests++;
        if (!ok || trig_log.size() !== 2 || packed_log(0) !== 16'h2800) begin
            fails++; $display("FAIL mask_trig: ok=%b n=%0d log=%h want 1 2 2800", ok, trig_log.size(), packed_log(0));
        end
        tests++;
        if (packed_log(2) !== 16'h1300 || cam_idx !== 2'd3) begin
            fails++; $display("FAIL mask_idx: log=%h idx=%0d want 1300 3", packed_log(2), cam_idx);
        end
        cam_en = 4'b0000;
        clear_logs();
        pulse_trig();
        repeat (20) @(posedge rclk);
        #1;
        tests++;
        if (trig_log.size() !== 0 || done_cnt !== 0 || busy_seen !== 1'b0) begin
            fails++; $display("FAIL mask_zero: n_trig=%0d done=%0d busy_seen=%b want 0 0 0", trig_log.size(), done_cnt, busy_seen);
        end
        tests++;
        if (cam_idx !== 2'd3) begin
            fails++; $display("FAIL mask_hold_idx: idx=%0d want 3", cam_idx);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        cam_en = 4'b1111;
        stuck = 4'b0100;
        clear_logs();
        pulse_trig();
        wait_trig(4'b0100, 200, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL to_reach_cam2: ch_trig 0100 not seen"); end
        repeat (100) @(posedge rclk);
        #1;
        tests++;
        if (timeout !== 4'b0000 || error !== 1'b0) begin
            fails++; $display("FAIL to_early: timeout=%b error=%b want 0000 0 at wait cycle 100", timeout, error);
        end
        @(posedge rclk); #1;
        tests++;
        if (timeout !== 4'b0100 || error !== 1'b1 || cam_idx !== 2'd3) begin
            fails++; $display("FAIL to_fire: timeout=%b error=%b idx=%0d want 0100 1 3", timeout, error, cam_idx);
        end
        wait_done(1, 300, ok);
        stuck = 4'b0000;
        repeat (3) @(posedge rclk);
        #1;
        tests++;
        if (!ok || packed_log(0) !== 16'h1248 || timeout !== 4'b0100) begin
            fails++; $display("FAIL to_continue: ok=%b log=%h timeout=%b want 1 1248 0100", ok, packed_log(0), timeout);
        end
        pulse_clr();
        tests++;
        if (timeout !== 4'b0000 || error !== 1'b0) begin
            fails++; $display("FAIL to_clr: timeout=%b error=%b want 0000 0", timeout, error);
        end
        ch_err = 4'b0010;
        #1;
        tests++;
        if (error !== 1'b1) begin fails++; $display("FAIL ch_err_or: error=%b want 1", error); end
        ch_err = 4'b0000;
        #1;
    endtask

    task automatic test_queue();
        bit ok;
        cam_en = 4'b0001;
        clear_logs();
        pulse_trig();
        repeat (3) @(posedge rclk);
        #1;
        pulse_trig();
        wait_done(2, 200, ok);
        repeat (30) @(posedge rclk);
        #1;
        tests++;
        if (!ok || done_cnt !== 2 || packed_log(0) !== 16'h1100 || error !== 1'b0) begin
            fails++; $display("FAIL queue_single: ok=%b done=%0d log=%h error=%b want 1 2 1100 0", ok, done_cnt, packed_log(0), error);
        end
        clear_logs();
        pulse_trig();
        repeat (3) @(posedge rclk);
        #1;
        pulse_trig();
        repeat (2) @(posedge rclk);
        #1;
        pulse_trig();
        wait_done(2, 200, ok);
        repeat (30) @(posedge rclk);
        #1;
        tests++;
        if (!ok || done_cnt !== 2 || trig_log.size() !== 2 || error !== 1'b1) begin
            fails++; $display("FAIL queue_drop: ok=%b done=%0d n=%0d error=%b want 1 2 2 1", ok, done_cnt, trig_log.size(), error);
        end
        pulse_clr();
        tests++;
        if (error !== 1'b0) begin fails++; $display("FAIL queue_clr: error=%b want 0", error); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        cam_en = 4'b0001;
        clear_logs();
        pulse_trig();
        wait_trig(4'b0001, 20, ok);
        // busy stays high for BUSY_LEN cycles after ARM; the next cycle is the last WAIT
        repeat (BUSY_LEN + 1) @(posedge rclk);
        #1;
        pulse_trig();
        tests++;
        if (!ok || done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_done: ok=%b done=%b busy=%b want 1 1 0", ok, done, busy);
        end
        @(posedge rclk); #1;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_restart: busy=%b want 1", busy); end
        @(posedge rclk); #1;
        tests++;
        if (ch_trig !== 4'b0001) begin fails++; $display("FAIL b2b_trig: ch_trig=%b want 0001", ch_trig); end
        wait_done(2, 100, ok);
        tests++;
        if (!ok || error !== 1'b0) begin
            fails++; $display("FAIL b2b_end: ok=%b error=%b want 1 0", ok, error);
        end
    endtask

    task automatic test_read_route();
        bit ok;
        cam_en = 4'b1111;
        read_en = 1'b1;
        chk_re = 1;
        clear_logs();
        pulse_trig();
        wait_done(1, 300, ok);
        chk_re = 0;
        read_en = 1'b0;
        #1;
        tests++;
        if (!ok || ch_re !== 4'b0000) begin
            fails++; $display("FAIL read_off: ok=%b ch_re=%b want 1 0000", ok, ch_re);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cam_en = 4'b1111;
        clear_logs();
        pulse_trig();
        wait_trig(4'b0010, 100, ok);
        repeat (3) @(posedge rclk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (!ok || busy !== 1'b0 || ch_trig !== 4'b0000 || done !== 1'b0) begin
            fails++; $display("FAIL rst_mid_ctl: ok=%b busy=%b ch_trig=%b done=%b want 1 0 0000 0", ok, busy, ch_trig, done);
        end
        tests++;
        if (cam_idx !== 2'd0 || cam_id !== 4'b1000 || timeout !== 4'b0000) begin
            fails++; $display("FAIL rst_mid_route: idx=%0d id=%b timeout=%b want 0 1000 0000", cam_idx, cam_id, timeout);
        end
        @(posedge rclk); #1;
        rst = 1'b0;
        @(posedge rclk); #1;
        clear_logs();
        pulse_trig();
        wait_done(1, 300, ok);
        tests++;
        if (!ok || packed_log(0) !== 16'h1248) begin
            fails++; $display("FAIL rst_restart: ok=%b log=%h want 1 1248", ok, packed_log(0));
        end
        repeat (2) @(posedge rclk);
        #1;
        pulse_trig();
        wait_trig(4'b0001, 10, ok);
        rst = 1'b1;
        #1;
        tests++;
        if (!ok || ch_trig !== 4'b0000) begin
            fails++; $display("FAIL rst_cut_pulse: ok=%b ch_trig=%b want 1 0000", ok, ch_trig);
        end
        @(posedge rclk); #1;
        rst = 1'b0;
        @(posedge rclk); #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_all_cams();
        test_mask();
        test_timeout();
        test_queue();
        test_back_to_back();
        test_read_route();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench stalled");
    end

endmodule
